// File: rtl/weight_pkg.sv
// Shared widths, counts and loader state encoding for the weight-bank write path.
package weight_pkg;

    localparam int WGT_W     = 72;   // 3x3 int8 kernel word
    localparam int DMA_W     = 64;   // DMA stream beat
    localparam int GRP       = 8;    // channels per config group
    localparam int CFG_GRP_W = 10;
    localparam int BUF_W     = 136;  // worst-case fill is 135 bits
    localparam int FILL_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        WAIT_WC,
        DONE
    } ldr_state_t;

endpackage

// File: rtl/gearbox_64to72.sv
// Regears 64-bit beats into 72-bit words through a 136-bit shift buffer.
module gearbox_64to72
    import weight_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [DMA_W-1:0] in_data,
    input  logic             emit_en,
    output logic             emit,
    output logic             out_valid,
    output logic [WGT_W-1:0] out_data
);

    logic [BUF_W-1:0]  data_buf, buf_base, buf_next;
    logic [FILL_W-1:0] fill, fill_base, fill_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        emit      = emit_en && (fill >= FILL_W'(WGT_W));
        buf_base  = emit ? (data_buf >> WGT_W) : data_buf;
        fill_base = emit ? (fill - FILL_W'(WGT_W)) : fill;
        buf_next  = buf_base;
        fill_next = fill_base;
        // Bits above fill are always zero, so OR-ing the new beat in place is safe.
        if (in_valid) begin
            buf_next  = buf_base | ({{(BUF_W-DMA_W){1'b0}}, in_data} << fill_base);
            fill_next = fill_base + FILL_W'(DMA_W);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the buffer is a flop register, not a RAM, so it is reset alongside the fill count.
        if (rst) begin
            data_buf  <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            data_buf  <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            data_buf  <= buf_next;
            fill      <= fill_next;
            out_valid <= emit;
            if (emit) begin
                out_data <= data_buf[WGT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Streams a 64-bit DMA weight image into the weight bank as 72-bit kernel words.
module weight_stream_loader
    import weight_pkg::*;
#(
    parameter int IN_W  = 64,
    parameter int OUT_W = 72,
    parameter int CNT_W = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CFG_GRP_W-1:0] cfg_ci_groups,
    input  logic [CFG_GRP_W-1:0] cfg_co_groups,
    input  logic [IN_W-1:0]      s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    output logic                 write_mode,
    output logic                 data_valid,
    output logic [OUT_W-1:0]     data_in,
    input  logic                 write_complete,
    output logic                 busy,
    output logic                 done,
    output logic                 err_len
);

    ldr_state_t           state, state_next;
    logic [CFG_GRP_W-1:0] ci_q, co_q;
    logic [CNT_W-1:0]     in_cnt, out_cnt, grp_prod, n_in, n_out;
    logic                 accept, cfg_bad, in_hs, emit, emit_en, last_beat;

    assign grp_prod  = CNT_W'(ci_q) * CNT_W'(co_q);
    assign n_out     = grp_prod * CNT_W'(GRP * GRP);
    assign n_in      = grp_prod * CNT_W'(WGT_W);
    assign cfg_bad   = (cfg_ci_groups == '0) || (cfg_co_groups == '0);
    assign accept    = (state == IDLE) && start;
    assign in_hs     = s_tvalid && s_tready;
    assign last_beat = (in_cnt == n_in - CNT_W'(1));
    assign emit_en   = ((state == LOAD) || (state == DRAIN)) && (out_cnt < n_out);

    always_comb begin
        state_next = state;
        s_tready   = 1'b0;
        write_mode = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = cfg_bad ? DONE : LOAD;
            end
            LOAD: begin
                write_mode = 1'b1;
                s_tready   = (in_cnt < n_in);
                if (in_cnt == n_in) state_next = DRAIN;
            end
            DRAIN: begin
                write_mode = 1'b1;
                if (out_cnt == n_out) state_next = WAIT_WC;
            end
            WAIT_WC: begin
                write_mode = 1'b1;
                if (write_complete) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ci_q    <= '0;
            co_q    <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            err_len <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                ci_q    <= cfg_ci_groups;
                co_q    <= cfg_co_groups;
                in_cnt  <= '0;
                out_cnt <= '0;
                err_len <= cfg_bad;
            end else begin
                // Completion is counted; tlast only flags a length mismatch.
                if (in_hs) begin
                    in_cnt <= in_cnt + CNT_W'(1);
                    if (s_tlast != last_beat) err_len <= 1'b1;
                end
                if (emit) out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

    gearbox_64to72 u_gearbox (
        .clk       (clk),
        .rst       (rst),
        .flush     (accept),
        .in_valid  (in_hs),
        .in_data   (s_tdata),
        .emit_en   (emit_en),
        .emit      (emit),
        .out_valid (data_valid),
        .out_data  (data_in)
    );

endmodule

// File: doc/weight_stream_loader.md
Name: weight_stream_loader

Overview:
- Transmit side of the weight-bank write interface: drives the weight-bank write port (write_mode, data_valid, data_in[71:0]) and consumes its write_complete.
- Accepts a 64-bit DMA stream, regears it into 72-bit 3x3 int8 kernel words and emits exactly 64*cfg_ci_groups*cfg_co_groups words in stream order.
- Holds write_mode for the whole transfer, waits for write_complete, then reports done.

Parameters:
- IN_W, 64, input stream width; fixed, the gearbox is specified for 64 only.
- OUT_W, 72, output word width (9 x int8).
- CNT_W, 27, width of the input and output word counters; covers 72*1023*1023.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- cfg_ci_groups  in  10  input-channel groups of 8; latched on start
- cfg_co_groups  in  10  output-channel groups of 8; latched on start
- s_tdata  in  64  stream data; little-endian bit order
- s_tvalid  in  1  stream valid
- s_tready  out  1  stream ready
- s_tlast  in  1  marks the final stream word
- write_mode  out  1  to the weight bank; high from LOAD entry until DONE
- data_valid  out  1  to the weight bank; one 72-bit word per cycle when high
- data_in  out  72  to the weight bank
- write_complete  in  1  from the weight bank
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of transfer
- err_len  out  1  sticky length/config error; cleared by the next accepted start

Behaviour:
- Reset: state=IDLE. All outputs 0. Buffer fill=0. Counters 0. The reset clause applies in any state; it abandons a transfer mid-flight and drops write_mode, which resets the weight-bank write counters.
- Derived counts from the latched config:
  - N_OUT = 64*ci*co output words.
  - N_IN = 72*ci*co input words; the bit counts match exactly, so no padding.
  - Multiply with zero-extension to CNT_W.
- State machine:
  - IDLE: on start, latch cfg, clear err_len, go to LOAD. If ci==0 or co==0, instead set err_len and pulse done next cycle; write_mode stays low.
  - LOAD: write_mode=1. s_tready=1 while in_cnt<N_IN. When in_cnt reaches N_IN, go to DRAIN.
  - DRAIN: s_tready=0. Emit until out_cnt==N_OUT, then go to WAIT_WC.
  - WAIT_WC: write_mode stays 1. On write_complete==1, go to DONE.
  - DONE: done=1 for one cycle, write_mode=0, then IDLE.
  - start outside IDLE is ignored.
- Gearbox:
  - 136-bit buffer with fill count 0..135.
  - An input handshake (s_tvalid & s_tready) appends s_tdata at bit position fill.
  - Whenever fill>=72 at a clock edge, bits [71:0] are registered onto data_in with data_valid=1, and the buffer shifts down by 72.
  - Append and emit can occur on the same edge: new fill = fill - 72 + 64.
  - fill never exceeds 135, so s_tready needs no fill-based backpressure.
  - data_valid is never high for more than N_OUT cycles total; out_cnt counts emitted words.
- Latency:
  - Handshakes on consecutive edges k and k+1 give fill=128 after edge k+1, so data_valid is first high after edge k+2.
  - Steady state at full input rate: 8 outputs per 9 inputs.
- Bit order: output word 0 bits [63:0] = input word 0; bits [71:64] = input word 1 bits [7:0].
- Length check:
  - s_tlast high on a handshake with in_cnt != N_IN-1 sets err_len; the word is still consumed.
  - s_tlast low on the final handshake also sets err_len.
  - The transfer always completes on counts, not on tlast.
- data_in holds its last value when data_valid=0.

Decomposition:
- Shared package weight_pkg:
  - WGT_W=72, DMA_W=64, GRP=8, CFG_GRP_W=10.
  - Enum ldr_state_t {IDLE, LOAD, DRAIN, WAIT_WC, DONE}.
- One sub-module, gearbox_64to72: buffer, fill counter, append/emit datapath, flush input.
- The FSM and counters stay in weight_stream_loader.

Test Plan:
- ci=1, co=1, 72 words, s_tvalid always 1, tlast on word 71, word i = {32'(i), 32'(~i)} -> exactly 64 data_valid cycles; word 0 = {in1[7:0], in0}; reference-model match; write_complete 1 cycle after last word -> done 1 cycle after that; err_len=0.
- ci=2, co=3, 432 input words, random s_tvalid gaps (50%) -> 384 outputs, bit-exact against model; write_mode continuous from LOAD to DONE.
- ci=1, co=1, tlast asserted on word 10 -> err_len=1; transfer still consumes 72 words, emits 64, and done pulses.
- write_complete held low for 20 cycles after the last output -> stays in WAIT_WC with busy=1 and write_mode=1; done only after write_complete rises.
- cfg_co_groups=0 on start -> err_len=1, done pulse, no data_valid, write_mode never high.
- rst asserted after 30 output words -> next cycle all outputs 0 and state IDLE; a following full ci=1, co=1 run is bit-exact.
